ctrl_pipe_hazard: RTL and testbench
===================================

Name: ctrl_pipe_hazard

Overview:
- Consumer end of the `control` decoder. Takes the ID-stage control bundle (ALUOp, ALUSrc, branch, mem_read, mem_write, reg_write, mem_to_reg) and carries it through the ID/EX, EX/MEM and MEM/WB control registers of the 5-stage RV32 pipeline.
- Detects load-use hazards and inserts bubbles. Flushes on a taken branch resolved in EX.
- Drives the EX-stage forwarding selects. Keeps saturating stall/flush event counters.

Parameters:
- RA_W, 5, register-address width.
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_aluop  in  2  ALUOp from control.
- id_alusrc, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  control outputs.
- id_rs1, id_rs2, id_rd  in  RA_W  instruction fields in ID.
- ex_zero  in  1  ALU zero flag in EX.
- ex_aluop  out  2  ALUOp in EX.
- ex_alusrc  out  1  ALUSrc in EX.
- ex_rs1, ex_rs2  out  RA_W  source addresses in EX.
- mem_branch_taken  out  1  registered branch decision (EX/MEM).
- mem_mem_read, mem_mem_write  out  1  memory controls in MEM.
- wb_reg_write, wb_mem_to_reg  out  1  write-back controls.
- wb_rd  out  RA_W  write-back destination.
- fwd_a, fwd_b  out  2  forwarding selects: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB.
- pc_write, if_id_write  out  1  fetch enables (0 = hold).
- if_id_flush  out  1  zero the IF/ID instruction register.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

Behaviour:
- Reset (rst_n = 0, asynchronous): all pipeline control and address registers clear to 0, which is a NOP bubble. Counters clear to 0. Combinational outputs follow from the cleared registers: pc_write = 1, if_id_write = 1, if_id_flush = 0, fwd_a = fwd_b = 00.
- Latency: an ID bundle appears on the ex_* outputs 1 cycle later, on mem_* 2 cycles later, and on wb_* 3 cycles later.
- Load-use (combinational): `stall = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2))`.
  - On stall: pc_write = 0, if_id_write = 0, and ID/EX loads an all-zero bubble at the next edge.
- Branch (combinational): `take = ex_branch & ex_zero`.
  - On take: if_id_flush = 1 and ID/EX loads a bubble at the next edge.
  - mem_branch_taken <= take.
- Priority: take overrides stall. When both are asserted, pc_write = 1, if_id_write = 1, the flush occurs, and only flush_cnt increments.
- Forwarding for fwd_a (fwd_b is identical using ex_rs2):
  - 10 if mem_reg_write & mem_rd != 0 & mem_rd == ex_rs1;
  - else 01 if wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1;
  - else 00.
  - EX/MEM takes priority over MEM/WB.
- x0 never triggers a stall or forward.
- EX/MEM and MEM/WB registers advance every cycle and are never stalled.
- Counters: stall_cnt increments on each cycle with stall & ~take. flush_cnt increments on each cycle with take. Both saturate at all-ones; there is no wrap.
- Reset mid-operation: in-flight bundles are discarded immediately (asynchronous). The first edge after release loads the current ID bundle.
- Control-bit widths are pass-through only; no arithmetic beyond the counters.

Decomposition:
- Package `pipe_pkg`:
  - ctrl_bundle_t struct {aluop[1:0], alusrc, branch, mem_read, mem_write, reg_write, mem_to_reg};
  - CTRL_NOP constant (all zeros);
  - FWD_RF = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01;
  - opcode localparams shared with `control`.
- One natural sub-module, `fwd_unit`: combinational forwarding compare, instantiated once and producing both fwd_a and fwd_b. Hazard logic and the pipeline registers stay in the top level.

Test Plan:
- Reset/latency: hold rst_n = 0 for 2 cycles → all outputs 0, pc_write = 1. Release, present an R-type bundle (aluop = 10, reg_write = 1, id_rd = 5) → ex_aluop = 10 at +1, wb_reg_write = 1 and wb_rd = 5 at +3.
- Load-use: lw with id_rd = 6 followed by add with rs1 = 6 → one cycle of pc_write = 0 and if_id_write = 0, then a bubble in EX (ex_aluop = 00, ex_alusrc = 0), stall_cnt = 1. With rs1 = 0 and rd = 0 instead → no stall.
- Branch: beq bundle (branch = 1, aluop = 01) with ex_zero = 1 in EX → if_id_flush = 1 that cycle, next ex_* is a bubble, mem_branch_taken = 1, flush_cnt = 1. With ex_zero = 0 → no flush.
- Simultaneous: taken beq in EX while a lw is in EX and a dependent instruction is in ID → flush wins, pc_write = 1, flush_cnt +1, stall_cnt unchanged.
- Forwarding: add x7 then sub x8, x7, x7 → fwd_a = fwd_b = 10. With one independent instruction in between → 01. Producer at both MEM and WB stages → 10.
- Saturation/async reset: build with CNT_W = 2 and force 5 stalls → stall_cnt = 3. Pulse rst_n low mid-clock → outputs clear without waiting for an edge.

Source files
------------

// File: rtl/ctrl_pipe_hazard_pkg.sv
// pipe_pkg: shared control-bundle type, forwarding select codes and opcodes
package pipe_pkg;
  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_bundle_t;
  localparam ctrl_bundle_t CTRL_NOP = '0;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// fwd_unit: EX-stage forwarding selects for both ALU operands
module fwd_unit import pipe_pkg::*; #(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);
  logic mem_ok, wb_ok;
  // the younger EX/MEM result wins over MEM/WB; x0 is never a forwarding source
  always_comb begin
    mem_ok = mem_reg_write && mem_rd != '0;
    wb_ok  = wb_reg_write && wb_rd != '0;
    fwd_a  = (mem_ok && mem_rd == ex_rs1) ? FWD_EXMEM : (wb_ok && wb_rd == ex_rs1) ? FWD_MEMWB : FWD_RF;
    fwd_b  = (mem_ok && mem_rd == ex_rs2) ? FWD_EXMEM : (wb_ok && wb_rd == ex_rs2) ? FWD_MEMWB : FWD_RF;
  end
endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: ID/EX, EX/MEM, MEM/WB control pipeline with load-use stall, branch flush and forwarding
module ctrl_pipe_hazard import pipe_pkg::*; #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      id_aluop,
  input  logic            id_alusrc,
  input  logic            id_branch,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            ex_zero,
  output logic [1:0]      ex_aluop,
  output logic            ex_alusrc,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic            mem_branch_taken,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic [RA_W-1:0] wb_rd,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            if_id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  ctrl_bundle_t    id_ctrl, ex_ctrl_q, ex_ctrl_d;
  logic [RA_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic [RA_W-1:0] mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic            mem_branch_taken_q, mem_branch_taken_d, mem_mem_read_q, mem_mem_read_d;
  logic            mem_mem_write_q, mem_mem_write_d, mem_reg_write_q, mem_reg_write_d;
  logic            mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic            wb_reg_write_q, wb_reg_write_d, wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic            stall, take, bubble;

  assign id_ctrl = {id_aluop, id_alusrc, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg};

  // hazard decisions, fetch enables and next state of every control register and counter
  always_comb begin
    stall              = ex_ctrl_q.mem_read && ex_rd_q != '0 && (ex_rd_q == id_rs1 || ex_rd_q == id_rs2);
    take               = ex_ctrl_q.branch && ex_zero;
    bubble             = stall || take;
    pc_write           = !stall || take;
    if_id_write        = !stall || take;
    if_id_flush        = take;
    ex_ctrl_d          = bubble ? CTRL_NOP : id_ctrl;
    ex_rs1_d           = bubble ? '0 : id_rs1;
    ex_rs2_d           = bubble ? '0 : id_rs2;
    ex_rd_d            = bubble ? '0 : id_rd;
    mem_branch_taken_d = take;
    mem_mem_read_d     = ex_ctrl_q.mem_read;
    mem_mem_write_d    = ex_ctrl_q.mem_write;
    mem_reg_write_d    = ex_ctrl_q.reg_write;
    mem_mem_to_reg_d   = ex_ctrl_q.mem_to_reg;
    mem_rd_d           = ex_rd_q;
    wb_reg_write_d     = mem_reg_write_q;
    wb_mem_to_reg_d    = mem_mem_to_reg_q;
    wb_rd_d            = mem_rd_q;
    stall_cnt_d        = (stall && !take && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d        = (take && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // pipeline registers; reset clears everything to a NOP bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q          <= CTRL_NOP;
      ex_rs1_q           <= '0;
      ex_rs2_q           <= '0;
      ex_rd_q            <= '0;
      mem_branch_taken_q <= 1'b0;
      mem_mem_read_q     <= 1'b0;
      mem_mem_write_q    <= 1'b0;
      mem_reg_write_q    <= 1'b0;
      mem_mem_to_reg_q   <= 1'b0;
      mem_rd_q           <= '0;
      wb_reg_write_q     <= 1'b0;
      wb_mem_to_reg_q    <= 1'b0;
      wb_rd_q            <= '0;
      stall_cnt_q        <= '0;
      flush_cnt_q        <= '0;
    end else begin
      ex_ctrl_q          <= ex_ctrl_d;
      ex_rs1_q           <= ex_rs1_d;
      ex_rs2_q           <= ex_rs2_d;
      ex_rd_q            <= ex_rd_d;
      mem_branch_taken_q <= mem_branch_taken_d;
      mem_mem_read_q     <= mem_mem_read_d;
      mem_mem_write_q    <= mem_mem_write_d;
      mem_reg_write_q    <= mem_reg_write_d;
      mem_mem_to_reg_q   <= mem_mem_to_reg_d;
      mem_rd_q           <= mem_rd_d;
      wb_reg_write_q     <= wb_reg_write_d;
      wb_mem_to_reg_q    <= wb_mem_to_reg_d;
      wb_rd_q            <= wb_rd_d;
      stall_cnt_q        <= stall_cnt_d;
      flush_cnt_q        <= flush_cnt_d;
    end
  end

  assign ex_aluop         = ex_ctrl_q.aluop;
  assign ex_alusrc        = ex_ctrl_q.alusrc;
  assign ex_rs1           = ex_rs1_q;
  assign ex_rs2           = ex_rs2_q;
  assign mem_branch_taken = mem_branch_taken_q;
  assign mem_mem_read     = mem_mem_read_q;
  assign mem_mem_write    = mem_mem_write_q;
  assign wb_reg_write     = wb_reg_write_q;
  assign wb_mem_to_reg    = wb_mem_to_reg_q;
  assign wb_rd            = wb_rd_q;
  assign stall_cnt        = stall_cnt_q;
  assign flush_cnt        = flush_cnt_q;

  fwd_unit #(.RA_W(RA_W)) u_fwd (
    .ex_rs1       (ex_rs1_q),
    .ex_rs2       (ex_rs2_q),
    .mem_reg_write(mem_reg_write_q),
    .mem_rd       (mem_rd_q),
    .wb_reg_write (wb_reg_write_q),
    .wb_rd        (wb_rd_q),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb_ctrl_pipe_hazard: directed table, randomized model comparison, async reset and counter saturation
module tb_ctrl_pipe_hazard;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] id_aluop;
  logic       id_alusrc, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_zero;
  logic [1:0] ex_aluop, fwd_a, fwd_b;
  logic       ex_alusrc, mem_branch_taken, mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg;
  logic       pc_write, if_id_write, if_id_flush;
  logic [4:0] ex_rs1, ex_rs2, wb_rd;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0] d2_ex_aluop, d2_fwd_a, d2_fwd_b;
  logic       d2_ex_alusrc, d2_mbt, d2_mmr, d2_mmw, d2_wrw, d2_wm2r, d2_pcw, d2_ifw, d2_iff;
  logic [4:0] d2_ex_rs1, d2_ex_rs2, d2_wb_rd;
  logic [1:0] d2_stall_cnt, d2_flush_cnt;

  always #5 clk = ~clk;

  ctrl_pipe_hazard dut (
    .clk(clk), .rst_n(rst_n), .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_branch_taken(mem_branch_taken), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ctrl_pipe_hazard #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_aluop(d2_ex_aluop), .ex_alusrc(d2_ex_alusrc), .ex_rs1(d2_ex_rs1), .ex_rs2(d2_ex_rs2),
    .mem_branch_taken(d2_mbt), .mem_mem_read(d2_mmr), .mem_mem_write(d2_mmw),
    .wb_reg_write(d2_wrw), .wb_mem_to_reg(d2_wm2r), .wb_rd(d2_wb_rd), .fwd_a(d2_fwd_a), .fwd_b(d2_fwd_b),
    .pc_write(d2_pcw), .if_id_write(d2_ifw), .if_id_flush(d2_iff),
    .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
  );

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc, branch, mrd, mwr, rw, m2r;
    logic [4:0] rs1, rs2, rd;
    logic       taken;
  } ins_t;

  typedef struct packed {
    ins_t       i;
    logic       z, pcw, fl;
    logic [1:0] fa, fb, eal;
  } row_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_st, m_fl, checks, errors, cyc;
  row_t tbl [20];

  function automatic ins_t mk(input logic [1:0] al, input logic as, br, mr, mw, rw, m2r,
                              input logic [4:0] s1, s2, d);
    return {al, as, br, mr, mw, rw, m2r, s1, s2, d, 1'b0};
  endfunction
  function automatic ins_t rt(input logic [4:0] s1, s2, d);
    return mk(2'b10, 0, 0, 0, 0, 1, 0, s1, s2, d);
  endfunction
  function automatic ins_t lw(input logic [4:0] s1, d);
    return mk(2'b00, 1, 0, 1, 0, 1, 1, s1, 5'd0, d);
  endfunction
  function automatic ins_t beq(input logic [4:0] s1, s2);
    return mk(2'b01, 0, 1, 0, 0, 0, 0, s1, s2, 5'd0);
  endfunction
  function automatic int sat(input int v, input int m);
    return v > m ? m : v;
  endfunction
  function automatic logic [1:0] efwd(input logic [4:0] rs);
    if (rs != 0 && m_mem.rw && m_mem.rd == rs) return 2'b10;
    if (rs != 0 && m_wb.rw && m_wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [1:0] haz();
    logic st, tk;
    st = m_ex.mrd && m_ex.rd != 0 && (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
    tk = m_ex.branch && ex_zero;
    return {st, tk};
  endfunction

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", n, cyc, got, exp);
    end
  endtask

  task automatic drive(input ins_t i, input logic z);
    id_aluop = i.aluop; id_alusrc = i.alusrc; id_branch = i.branch; id_mem_read = i.mrd;
    id_mem_write = i.mwr; id_reg_write = i.rw; id_mem_to_reg = i.m2r;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; ex_zero = z;
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_st = 0; m_fl = 0;
  endtask

  task automatic check_model();
    logic [1:0] h;
    h = haz();
    chk("ex", {ex_aluop, ex_alusrc, ex_rs1, ex_rs2}, {m_ex.aluop, m_ex.alusrc, m_ex.rs1, m_ex.rs2});
    chk("mem", {mem_branch_taken, mem_mem_read, mem_mem_write}, {m_mem.taken, m_mem.mrd, m_mem.mwr});
    chk("wb", {wb_reg_write, wb_mem_to_reg, wb_rd}, {m_wb.rw, m_wb.m2r, m_wb.rd});
    chk("fwd", {fwd_a, fwd_b}, {efwd(m_ex.rs1), efwd(m_ex.rs2)});
    chk("haz", {pc_write, if_id_write, if_id_flush}, {~h[1] | h[0], ~h[1] | h[0], h[0]});
    chk("cnt", {stall_cnt, flush_cnt}, {16'(sat(m_st, 65535)), 16'(sat(m_fl, 65535))});
    chk("cnt2", {d2_stall_cnt, d2_flush_cnt}, {2'(sat(m_st, 3)), 2'(sat(m_fl, 3))});
  endtask

  task automatic model_edge();
    logic [1:0] h;
    ins_t cur;
    h = haz();
    cur = mk(id_aluop, id_alusrc, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
             id_rs1, id_rs2, id_rd);
    if (h[0]) m_fl++;
    else if (h[1]) m_st++;
    m_wb = m_mem;
    m_mem = m_ex;
    m_mem.taken = h[0];
    m_ex = (h[0] || h[1]) ? '0 : cur;
    cyc++;
  endtask

  task automatic step(input ins_t i, input logic z);
    drive(i, z);
    #3;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    tbl[0]  = {rt(1, 2, 5),   1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[1]  = {lw(3, 6),      1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10};
    tbl[2]  = {rt(6, 4, 7),   1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[3]  = {rt(6, 4, 7),   1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[4]  = {rt(7, 7, 8),   1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b10};
    tbl[5]  = {rt(1, 2, 9),   1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b10};
    tbl[6]  = {rt(8, 7, 10),  1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10};
    tbl[7]  = {beq(0, 0),     1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b10};
    tbl[8]  = {rt(1, 2, 11),  1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01};
    tbl[9]  = {rt(1, 2, 12),  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[10] = {beq(1, 2),     1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10};
    tbl[11] = {rt(5, 6, 13),  1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01};
    tbl[12] = {mk(2'b01, 0, 1, 1, 0, 1, 1, 5'd3, 5'd4, 5'd14), 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10};
    tbl[13] = {rt(14, 0, 15), 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01};
    tbl[14] = {lw(3, 0),      1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[15] = {rt(0, 0, 0),   1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[16] = {rt(1, 2, 20),  1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10};
    tbl[17] = {rt(1, 2, 20),  1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10};
    tbl[18] = {rt(20, 20, 21), 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10};
    tbl[19] = {rt(1, 2, 22),  1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b10};
    rst_n = 1'b0;
    drive('0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(tbl[k].i, tbl[k].z);
      #3;
      check_model();
      chk($sformatf("tbl%0d", k), {pc_write, if_id_flush, fwd_a, fwd_b, ex_aluop},
          {tbl[k].pcw, tbl[k].fl, tbl[k].fa, tbl[k].fb, tbl[k].eal});
      @(posedge clk);
      model_edge();
      #1;
    end
    for (int k = 0; k < 300; k++)
      step(mk(2'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3))), 1'($urandom));
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(lw(3, 6), 1'b0);
      step(rt(6, 0, 7), 1'b0);
      step(rt(6, 0, 7), 1'b0);
    end
    #3;
    chk("sat16", stall_cnt, 16'd5);
    chk("sat2", d2_stall_cnt, 2'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
